// File: rtl/hex_byte_loader.sv
// Packs pairs of ASCII hex digits into bytes and pushes them to a FIFO write port.
// Latency: a byte is pushed one cycle after the edge that accepts its closing digit or separator.
// Backpressure: while a byte is pending, o_ready is low; a full FIFO either stalls or drops (DROP_ON_FULL).
module hex_byte_loader #(
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [7:0]       i_char,
    output logic             o_ready,
    output logic             o_wr,
    output logic [7:0]       o_data,
    input  logic             i_full,
    input  logic             i_clr_err,
    output logic             o_err,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HALF  = 2'd1,
        S_PUSH  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       nib_q, nib_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             is_digit;
    logic             is_sep;
    logic [3:0]       dig_val;
    logic             accept;
    logic             ready;
    logic             wr;
    logic             err_set;
    logic             ovf_set;

    // Character classification; letters map through their low nibble (A/a = 1 -> 10).
    always_comb begin
        is_digit = 1'b0;
        dig_val  = 4'h0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            is_digit = 1'b1;
            dig_val  = i_char[3:0];
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            is_digit = 1'b1;
            dig_val  = i_char[3:0] + 4'd9;
        end
        is_sep = (i_char == 8'h20) || (i_char == 8'h2C) ||
                 (i_char == 8'h0D) || (i_char == 8'h0A);
    end

    assign accept = i_valid && ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            nib_q   <= 4'h0;
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        byte_d  = byte_q;
        err_set = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        state_d = S_HALF;
                        nib_d   = dig_val;
                    end else if (!is_sep) begin
                        err_set = 1'b1;
                    end
                end
            end
            S_HALF: begin
                if (accept) begin
                    nib_d = 4'h0;
                    if (is_digit) begin
                        state_d = S_PUSH;
                        byte_d  = {nib_q, dig_val};
                    end else if (is_sep) begin
                        state_d = S_PUSH;
                        byte_d  = {4'h0, nib_q};
                    end else begin
                        state_d = S_IDLE;
                        err_set = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                if (!i_full) begin
                    state_d = S_IDLE;
                    byte_d  = 8'h00;
                end else if (DROP_ON_FULL != 0) begin
                    state_d = S_IDLE;
                    byte_d  = 8'h00;
                    ovf_set = 1'b1;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (!i_full) begin
                    state_d = S_IDLE;
                    byte_d  = 8'h00;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A set event wins over a simultaneous clear.
    always_comb begin
        err_d   = err_set | (err_q & ~i_clr_err);
        ovf_d   = ovf_set | (ovf_q & ~i_clr_err);
        count_d = count_q;
        if (wr && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        ready  = (state_q == S_IDLE) || (state_q == S_HALF);
        wr     = ((state_q == S_PUSH) || (state_q == S_STALL)) && !i_full;
        o_ready = ready;
        o_wr    = wr;
        o_data  = wr ? byte_q : 8'h00;
        o_err   = err_q;
        o_ovf   = ovf_q;
        o_count = count_q;
    end

endmodule

// File: tb/tb_hex_byte_loader.sv
// Directed bench for hex_byte_loader: stall, drop and narrow-counter variants share one stimulus stream.
module tb_hex_byte_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] chr = 8'h00;
    logic       full = 1'b0;
    logic       clr = 1'b0;

    logic       rdy0, wr0, err0, ovf0;
    logic [7:0] dat0, cnt0;
    logic       rdy1, wr1, err1, ovf1;
    logic [7:0] dat1, cnt1;
    logic       rdy2, wr2, err2, ovf2;
    logic [7:0] dat2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_byte_loader #(.DROP_ON_FULL(0), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_char(chr),
        .o_ready(rdy0), .o_wr(wr0), .o_data(dat0), .i_full(full),
        .i_clr_err(clr), .o_err(err0), .o_ovf(ovf0), .o_count(cnt0)
    );

    hex_byte_loader #(.DROP_ON_FULL(1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_char(chr),
        .o_ready(rdy1), .o_wr(wr1), .o_data(dat1), .i_full(full),
        .i_clr_err(clr), .o_err(err1), .o_ovf(ovf1), .o_count(cnt1)
    );

    hex_byte_loader #(.DROP_ON_FULL(0), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_char(chr),
        .o_ready(rdy2), .o_wr(wr2), .o_data(dat2), .i_full(full),
        .i_clr_err(clr), .o_err(err2), .o_ovf(ovf2), .o_count(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        valid = 1'b1;
        chr   = c;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chr   = 8'h00;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", rdy0); end
        checks++; if (wr0 !== 1'b0)   begin errors++; $display("FAIL reset_wr got %b exp 0", wr0); end
        checks++; if (dat0 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", dat0); end
        checks++; if (err0 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%b ovf=%b exp 0 0", err0, ovf1); end
        checks++; if (cnt0 !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0/0", cnt0, cnt2); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send("3");
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL basic_half got wr=%b rdy=%b exp 0 1", wr0, rdy0); end
        send("f");
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h3F) begin errors++; $display("FAIL basic_push got wr=%b data=%h exp 1 3f", wr0, dat0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL basic_push_ready got %b exp 0", rdy0); end
        step();
        checks++; if (wr0 !== 1'b0 || dat0 !== 8'h00 || cnt0 !== 8'd1) begin errors++; $display("FAIL basic_after got wr=%b data=%h cnt=%0d exp 0 00 1", wr0, dat0, cnt0); end
        send(" ");
        step();
        checks++; if (wr0 !== 1'b0 || cnt0 !== 8'd1 || err0 !== 1'b0) begin errors++; $display("FAIL basic_sep got wr=%b cnt=%0d err=%b exp 0 1 0", wr0, cnt0, err0); end
    endtask

    task automatic test_sep_case();
        send("7");
        send(8'h0A);
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h07) begin errors++; $display("FAIL lf_push got wr=%b data=%h exp 1 07", wr0, dat0); end
        step();
        send("a");
        send("B");
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'hAB) begin errors++; $display("FAIL case_ab got wr=%b data=%h exp 1 ab", wr0, dat0); end
        step();
        send("C");
        send("d");
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'hCD) begin errors++; $display("FAIL case_cd got wr=%b data=%h exp 1 cd", wr0, dat0); end
        step();
        checks++; if (cnt0 !== 8'd4 || cnt1 !== 8'd4) begin errors++; $display("FAIL count_4 got %0d/%0d exp 4/4", cnt0, cnt1); end
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL count_sat got %0d exp 3", cnt2); end
    endtask

    task automatic test_error();
        send("1");
        send("G");
        checks++; if (wr0 !== 1'b0 || err0 !== 1'b1 || rdy0 !== 1'b1) begin errors++; $display("FAIL err_set got wr=%b err=%b rdy=%b exp 0 1 1", wr0, err0, rdy0); end
        send("2");
        send("2");
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h22) begin errors++; $display("FAIL err_then_22 got wr=%b data=%h exp 1 22", wr0, dat0); end
        step();
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err0); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err0); end
        clr = 1'b1;
        send("!");
        clr = 1'b0;
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", err0); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (err0 !== 1'b0 || cnt0 !== 8'd5) begin errors++; $display("FAIL err_end got err=%b cnt=%0d exp 0 5", err0, cnt0); end
    endtask

    task automatic test_stall_drop();
        full = 1'b1;
        send("5");
        send("5");
        checks++; if (wr0 !== 1'b0 || wr1 !== 1'b0 || rdy0 !== 1'b0) begin errors++; $display("FAIL full_push got wr0=%b wr1=%b rdy0=%b exp 0 0 0", wr0, wr1, rdy0); end
        step();
        checks++; if (rdy1 !== 1'b1 || ovf1 !== 1'b1 || wr1 !== 1'b0 || cnt1 !== 8'd5) begin errors++; $display("FAIL drop got rdy=%b ovf=%b wr=%b cnt=%0d exp 1 1 0 5", rdy1, ovf1, wr1, cnt1); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (rdy0 !== 1'b0 || wr0 !== 1'b0) begin errors++; $display("FAIL stall_hold cycle %0d got rdy=%b wr=%b exp 0 0", i, rdy0, wr0); end
            step();
        end
        full = 1'b0;
        #1;
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h55 || ovf0 !== 1'b0) begin errors++; $display("FAIL stall_release got wr=%b data=%h ovf=%b exp 1 55 0", wr0, dat0, ovf0); end
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL drop_no_wr got %b exp 0", wr1); end
        step();
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1 || cnt0 !== 8'd6 || cnt1 !== 8'd5) begin errors++; $display("FAIL stall_after got wr=%b rdy=%b cnt0=%0d cnt1=%0d exp 0 1 6 5", wr0, rdy0, cnt0, cnt1); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf1); end
    endtask

    task automatic test_back_to_back();
        send("a");
        valid = 1'b1;
        chr   = "b";
        step();
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'hAB) begin errors++; $display("FAIL b2b_ab got wr=%b data=%h exp 1 ab", wr0, dat0); end
        chr = "c";
        step();
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ignored got wr=%b rdy=%b exp 0 1", wr0, rdy0); end
        step();
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_half got wr=%b rdy=%b exp 0 1", wr0, rdy0); end
        chr = " ";
        step();
        valid = 1'b0;
        chr   = 8'h00;
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h0C) begin errors++; $display("FAIL b2b_0c got wr=%b data=%h exp 1 0c", wr0, dat0); end
        step();
        checks++; if (cnt0 !== 8'd8 || cnt1 !== 8'd7 || cnt2 !== 2'd3) begin errors++; $display("FAIL b2b_count got %0d/%0d/%0d exp 8/7/3", cnt0, cnt1, cnt2); end
    endtask

    task automatic test_reset_mid();
        send("9");
        rst_n = 1'b0;
        #2;
        checks++; if (wr0 !== 1'b0 || dat0 !== 8'h00 || rdy0 !== 1'b1) begin errors++; $display("FAIL rst_mid_out got wr=%b data=%h rdy=%b exp 0 00 1", wr0, dat0, rdy0); end
        checks++; if (cnt0 !== 8'd0 || err0 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL rst_mid_state got cnt=%0d err=%b ovf=%b exp 0 0 0", cnt0, err0, ovf1); end
        rst_n = 1'b1;
        send("0");
        send("1");
        checks++; if (wr0 !== 1'b1 || dat0 !== 8'h01) begin errors++; $display("FAIL rst_mid_01 got wr=%b data=%h exp 1 01", wr0, dat0); end
        step();
        checks++; if (cnt0 !== 8'd1 || cnt2 !== 2'd1) begin errors++; $display("FAIL rst_mid_count got %0d/%0d exp 1/1", cnt0, cnt2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sep_case();
        test_error();
        test_stall_drop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
